top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-003 SHALL have ports: Instruction  out  32  instruction held in the IF/ID register.
REQ-004 SHALL have ports: ALU_A, ALU_B  out  32 each  EX-stage ALU operands (ALU_B is the sign-extended immediate when alusrc=1, else the rt data).
REQ-005 SHALL have ports: aluout  out  32  EX-stage ALU result (combinational).
REQ-006 SHALL have ports: regdst, alusrc, memread, memwrite, memtoreg, regwrite  out  1 each; aluop  out  2  ID/EX control fields.
REQ-007 SHALL have ports: alucontrol  out  3; writereg  out  5; Read_reg_data_2  out  32  EX-stage ALU select, destination register (rd if regdst, else rt), ID/EX rt data.

Function
REQ-008 SHALL implement a 5-stage in-order pipeline (IF, ID, EX, MEM, WB) with IF/ID, ID/EX, EX/MEM and MEM/WB registers; no forwarding, no stalls, no branches.
REQ-009 SHALL update PC by +4 every cycle; instruction ROM has 32 words indexed by PC[6:2], and PC wraps from 124 to 0.
REQ-010 SHALL preload the ROM words 0-6 as 0x00221820 add $3,$1,$2; 0x00412022 sub $4,$2,$1; 0x00C72824 and $5,$6,$7; 0x00C94025 or $8,$6,$9; 0x0022502A slt $10,$1,$2; 0xAC070004 sw $7,4($0); 0x8C0B0004 lw $11,4($0); all remaining words SHALL be 0x00000000.
REQ-011 SHALL decode in ID: R-type (op 0) regdst=1 regwrite=1 aluop=10; lw (0x23) alusrc=1 memread=1 memtoreg=1 regwrite=1 aluop=00; sw (0x2B) alusrc=1 memwrite=1 aluop=00; every other opcode SHALL drive all control bits 0 (NOP).
REQ-012 SHALL derive alucontrol: aluop 00 -> 010 (add); aluop 01 -> 110 (sub); aluop 10 decodes funct as 0x20 -> 010, 0x22 -> 110, 0x24 -> 000, 0x25 -> 001, 0x2A -> 111 (slt), and any other funct -> 010.
REQ-013 SHALL compute 32-bit wrap-around add/sub, bitwise and/or, and signed slt yielding 1 or 0.
REQ-014 SHALL provide a 32x32 register file with $0 hardwired to 0, two combinational reads and one write on the rising edge in WB; a same-cycle write to a read register (other than $0) SHALL be bypassed to the read data.
REQ-015 SHALL provide a 32-word data memory indexed by address[6:2]; writes occur on the rising edge in MEM when memwrite=1, reads are combinational when memread=1 (otherwise 0).
REQ-016 SHALL write back the memory data when memtoreg=1, else the ALU result, to writereg when regwrite=1.
REQ-017 SHALL produce these timings after reset deasserts: the rising edge n (n>=1) loads ROM word n-1 into IF/ID; the instruction is in EX after edge n+1; its register write occurs on edge n+4.
REQ-018 SHALL leave $0 unchanged on a write to $0.

Reset
REQ-019 SHALL, while reset=1, clear PC, all pipeline registers and data memory to 0, and all outputs SHALL read 0.
REQ-020 SHALL initialise register file entry i to value i (i=0..31) on reset.
REQ-021 SHALL restart from PC=0 with a fresh register file when reset is asserted mid-program.

Verification
REQ-022 SHALL pass this test: release reset, 1 edge -> Instruction=0x00221820; edge 2 -> ALU_A=1, ALU_B=2, aluout=3, alucontrol=010, regdst=1, regwrite=1, aluop=10, writereg=3.
REQ-023 SHALL pass this test: edges 3-6 -> aluout sequence 1 (sub), 6 (and), 15 (or), 1 (slt), with alucontrol 110, 000, 001, 111.
REQ-024 SHALL pass this test: edge 7 (sw in EX) -> alusrc=1, memwrite=1, ALU_B=4, aluout=4, Read_reg_data_2=7, regwrite=0.
REQ-025 SHALL pass this test: edge 8 (lw in EX) -> memread=1, memtoreg=1, writereg=11; after edge 11, $11=7; and $3=3, $4=1, $5=6, $8=15, $10=1 hold after all writebacks.
REQ-026 SHALL pass this test: assert reset mid-run -> all outputs 0 at once; release -> sequence of REQ-022 repeats exactly.
REQ-027 SHALL pass this test: run 40 edges -> PC wraps to 0 and instruction word 0 is fetched again; NOP slots show all control bits 0.

Source files
------------

// File: rtl/top.sv
// Five-stage in-order pipeline (IF, ID, EX, MEM, WB) with a fixed instruction ROM.
// There is no forwarding, no stalling and no branching. EX-stage signals are exposed as outputs.
module top (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] Instruction,
    output logic [31:0] ALU_A,
    output logic [31:0] ALU_B,
    output logic [31:0] aluout,
    output logic        regdst,
    output logic        alusrc,
    output logic        memread,
    output logic        memwrite,
    output logic        memtoreg,
    output logic        regwrite,
    output logic [1:0]  aluop,
    output logic [2:0]  alucontrol,
    output logic [4:0]  writereg,
    output logic [31:0] Read_reg_data_2
);
    localparam int unsigned XLEN   = 32;
    localparam int unsigned PC_W   = 7;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned NWORDS = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef struct packed {
        logic       regdst;
        logic       alusrc;
        logic       memread;
        logic       memwrite;
        logic       memtoreg;
        logic       regwrite;
        logic [1:0] aluop;
    } ctrl_t;

    // IF: a 7-bit PC makes the wrap from 124 back to 0 happen without extra logic
    logic [PC_W-1:0] r_pc;
    logic [XLEN-1:0] w_rom_word;
    logic [XLEN-1:0] r_ifid_instr;

    always_comb begin
        w_rom_word = '0;
        case (r_pc[6:2])
            5'd0: w_rom_word = 32'h0022_1820;
            5'd1: w_rom_word = 32'h0041_2022;
            5'd2: w_rom_word = 32'h00C7_2824;
            5'd3: w_rom_word = 32'h00C9_4025;
            5'd4: w_rom_word = 32'h0022_502A;
            5'd5: w_rom_word = 32'hAC07_0004;
            5'd6: w_rom_word = 32'h8C0B_0004;
            default: w_rom_word = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc         <= '0;
            r_ifid_instr <= '0;
        end else begin
            r_pc         <= r_pc + PC_W'(4);
            r_ifid_instr <= w_rom_word;
        end
    end

    // ID: decode. The all-zero filler word is a true bubble, so it drives no control bits.
    logic [5:0]  w_op;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    ctrl_t       w_ctrl;

    assign w_op = r_ifid_instr[31:26];
    assign w_rs = r_ifid_instr[25:21];
    assign w_rt = r_ifid_instr[20:16];
    assign w_rd = r_ifid_instr[15:11];

    always_comb begin
        w_ctrl = '0;
        if (r_ifid_instr != '0) begin
            case (w_op)
                OP_RTYPE: begin
                    w_ctrl.regdst   = 1'b1;
                    w_ctrl.regwrite = 1'b1;
                    w_ctrl.aluop    = 2'b10;
                end
                OP_LW: begin
                    w_ctrl.alusrc   = 1'b1;
                    w_ctrl.memread  = 1'b1;
                    w_ctrl.memtoreg = 1'b1;
                    w_ctrl.regwrite = 1'b1;
                end
                OP_SW: begin
                    w_ctrl.alusrc   = 1'b1;
                    w_ctrl.memwrite = 1'b1;
                end
                default: w_ctrl = '0;
            endcase
        end
    end

    // Register file. A write happening in WB this cycle is bypassed to the ID reads.
    logic [XLEN-1:0] r_regs [NREGS];
    logic            r_memwb_regwrite;
    logic [4:0]      r_memwb_dst;
    logic [XLEN-1:0] w_wb_data;
    logic [XLEN-1:0] w_rs_data;
    logic [XLEN-1:0] w_rt_data;
    logic            w_wb_en;

    assign w_wb_en = r_memwb_regwrite && (r_memwb_dst != 5'd0);

    always_comb begin
        w_rs_data = r_regs[w_rs];
        if (w_rs == 5'd0)
            w_rs_data = '0;
        else if (w_wb_en && r_memwb_dst == w_rs)
            w_rs_data = w_wb_data;
    end

    always_comb begin
        w_rt_data = r_regs[w_rt];
        if (w_rt == 5'd0)
            w_rt_data = '0;
        else if (w_wb_en && r_memwb_dst == w_rt)
            w_rt_data = w_wb_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++)
                r_regs[i] <= XLEN'(i);
        end else if (w_wb_en) begin
            r_regs[r_memwb_dst] <= w_wb_data;
        end
    end

    // ID/EX register
    ctrl_t           r_idex_ctrl;
    logic [XLEN-1:0] r_idex_a;
    logic [XLEN-1:0] r_idex_b;
    logic [XLEN-1:0] r_idex_imm;
    logic [4:0]      r_idex_rt;
    logic [4:0]      r_idex_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idex_ctrl <= '0;
            r_idex_a    <= '0;
            r_idex_b    <= '0;
            r_idex_imm  <= '0;
            r_idex_rt   <= '0;
            r_idex_rd   <= '0;
        end else begin
            r_idex_ctrl <= w_ctrl;
            r_idex_a    <= w_rs_data;
            r_idex_b    <= w_rt_data;
            r_idex_imm  <= {{16{r_ifid_instr[15]}}, r_ifid_instr[15:0]};
            r_idex_rt   <= w_rt;
            r_idex_rd   <= w_rd;
        end
    end

    // EX: ALU control, operand select and ALU
    logic [2:0]      w_aluctl;
    logic [XLEN-1:0] w_alu_b;
    logic [XLEN-1:0] w_alu_y;
    logic [4:0]      w_dst;

    always_comb begin
        w_aluctl = 3'b010;
        case (r_idex_ctrl.aluop)
            2'b00: w_aluctl = 3'b010;
            2'b01: w_aluctl = 3'b110;
            2'b10: begin
                case (r_idex_imm[5:0])
                    6'h20:   w_aluctl = 3'b010;
                    6'h22:   w_aluctl = 3'b110;
                    6'h24:   w_aluctl = 3'b000;
                    6'h25:   w_aluctl = 3'b001;
                    6'h2A:   w_aluctl = 3'b111;
                    default: w_aluctl = 3'b010;
                endcase
            end
            default: w_aluctl = 3'b010;
        endcase
    end

    assign w_alu_b = r_idex_ctrl.alusrc ? r_idex_imm : r_idex_b;
    assign w_dst   = r_idex_ctrl.regdst ? r_idex_rd : r_idex_rt;

    always_comb begin
        w_alu_y = '0;
        case (w_aluctl)
            3'b010:  w_alu_y = r_idex_a + w_alu_b;
            3'b110:  w_alu_y = r_idex_a - w_alu_b;
            3'b000:  w_alu_y = r_idex_a & w_alu_b;
            3'b001:  w_alu_y = r_idex_a | w_alu_b;
            3'b111:  w_alu_y = {31'b0, $signed(r_idex_a) < $signed(w_alu_b)};
            default: w_alu_y = '0;
        endcase
    end

    // EX/MEM register
    logic            r_exmem_memread;
    logic            r_exmem_memwrite;
    logic            r_exmem_memtoreg;
    logic            r_exmem_regwrite;
    logic [XLEN-1:0] r_exmem_alu;
    logic [XLEN-1:0] r_exmem_wdata;
    logic [4:0]      r_exmem_dst;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_exmem_memread  <= 1'b0;
            r_exmem_memwrite <= 1'b0;
            r_exmem_memtoreg <= 1'b0;
            r_exmem_regwrite <= 1'b0;
            r_exmem_alu      <= '0;
            r_exmem_wdata    <= '0;
            r_exmem_dst      <= '0;
        end else begin
            r_exmem_memread  <= r_idex_ctrl.memread;
            r_exmem_memwrite <= r_idex_ctrl.memwrite;
            r_exmem_memtoreg <= r_idex_ctrl.memtoreg;
            r_exmem_regwrite <= r_idex_ctrl.regwrite;
            r_exmem_alu      <= w_alu_y;
            r_exmem_wdata    <= r_idex_b;
            r_exmem_dst      <= w_dst;
        end
    end

    // MEM: word-addressed data memory, combinational read
    logic [XLEN-1:0] r_dmem [NWORDS];
    logic [XLEN-1:0] w_mem_rdata;

    assign w_mem_rdata = r_exmem_memread ? r_dmem[r_exmem_alu[6:2]] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NWORDS; i++)
                r_dmem[i] <= '0;
        end else if (r_exmem_memwrite) begin
            r_dmem[r_exmem_alu[6:2]] <= r_exmem_wdata;
        end
    end

    // MEM/WB register
    logic            r_memwb_memtoreg;
    logic [XLEN-1:0] r_memwb_rdata;
    logic [XLEN-1:0] r_memwb_alu;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_memwb_memtoreg <= 1'b0;
            r_memwb_regwrite <= 1'b0;
            r_memwb_rdata    <= '0;
            r_memwb_alu      <= '0;
            r_memwb_dst      <= '0;
        end else begin
            r_memwb_memtoreg <= r_exmem_memtoreg;
            r_memwb_regwrite <= r_exmem_regwrite;
            r_memwb_rdata    <= w_mem_rdata;
            r_memwb_alu      <= r_exmem_alu;
            r_memwb_dst      <= r_exmem_dst;
        end
    end

    assign w_wb_data = r_memwb_memtoreg ? r_memwb_rdata : r_memwb_alu;

    // Observation ports; alucontrol is forced low during reset so every output reads 0
    assign Instruction     = r_ifid_instr;
    assign ALU_A           = r_idex_a;
    assign ALU_B           = w_alu_b;
    assign aluout          = w_alu_y;
    assign regdst          = r_idex_ctrl.regdst;
    assign alusrc          = r_idex_ctrl.alusrc;
    assign memread         = r_idex_ctrl.memread;
    assign memwrite        = r_idex_ctrl.memwrite;
    assign memtoreg        = r_idex_ctrl.memtoreg;
    assign regwrite        = r_idex_ctrl.regwrite;
    assign aluop           = r_idex_ctrl.aluop;
    assign alucontrol      = reset ? 3'b000 : w_aluctl;
    assign writereg        = w_dst;
    assign Read_reg_data_2 = r_idex_b;

endmodule

// File: tb/tb_top.sv
// Bench for the five-stage pipeline. An architectural model retires ROM instructions
// with plain arithmetic and predicts the EX-stage view after every clock edge.
module tb_top;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instruction, ALU_A, ALU_B, aluout, Read_reg_data_2;
    logic        regdst, alusrc, memread, memwrite, memtoreg, regwrite;
    logic [1:0]  aluop;
    logic [2:0]  alucontrol;
    logic [4:0]  writereg;

    top dut (
        .clk(clk), .reset(reset), .Instruction(Instruction), .ALU_A(ALU_A), .ALU_B(ALU_B),
        .aluout(aluout), .regdst(regdst), .alusrc(alusrc), .memread(memread),
        .memwrite(memwrite), .memtoreg(memtoreg), .regwrite(regwrite), .aluop(aluop),
        .alucontrol(alucontrol), .writereg(writereg), .Read_reg_data_2(Read_reg_data_2)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [31:0] word, a, b, rt, res, load;
        logic [7:0]  ctrl;   // {regdst,alusrc,memread,memwrite,memtoreg,regwrite,aluop}
        logic [2:0]  actl;
        logic [4:0]  dst;
    } rec_t;

    logic [31:0] rom [32];
    logic [31:0] m_regs [32];
    logic [31:0] m_mem [32];
    rec_t        recs [8];
    int          m_e;

    function automatic void decode(input logic [31:0] w, output logic [7:0] ctrl, output logic [2:0] actl);
        logic [5:0] op;
        logic [5:0] fn;
        op = w[31:26];
        fn = w[5:0];
        if (w == 32'h0)        ctrl = 8'b0000_0000;
        else if (op == 6'h00)  ctrl = 8'b1000_0110;
        else if (op == 6'h23)  ctrl = 8'b0110_1100;
        else if (op == 6'h2B)  ctrl = 8'b0101_0000;
        else                   ctrl = 8'b0000_0000;
        actl = 3'd2;
        if (ctrl[1:0] == 2'b01) actl = 3'd6;
        if (ctrl[1:0] == 2'b10) begin
            if (fn == 6'h22) actl = 3'd6;
            if (fn == 6'h24) actl = 3'd0;
            if (fn == 6'h25) actl = 3'd1;
            if (fn == 6'h2A) actl = 3'd7;
        end
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            3'd2:    return a + b;
            3'd6:    return a - b;
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic rec_t make_rec(input logic [31:0] w);
        rec_t r;
        logic [31:0] imm;
        r.word = w;
        decode(w, r.ctrl, r.actl);
        imm    = {{16{w[15]}}, w[15:0]};
        r.a    = m_regs[w[25:21]];
        r.rt   = m_regs[w[20:16]];
        r.b    = r.ctrl[6] ? imm : r.rt;
        r.res  = alu(r.actl, r.a, r.b);
        r.dst  = r.ctrl[7] ? w[15:11] : w[20:16];
        r.load = 32'd0;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_regs[i] = 32'(i);
            m_mem[i]  = 32'd0;
        end
        for (int i = 0; i < 8; i++) recs[i] = make_rec(32'd0);
        m_e = 0;
    endtask

    // One clock edge: instruction loaded on edge n does MEM on n+3, WB on n+4.
    task automatic model_edge();
        int n;
        m_e++;
        n = m_e - 3;
        if (n >= 1 && recs[n % 8].ctrl[4]) m_mem[recs[n % 8].res[6:2]] = recs[n % 8].rt;
        n = m_e - 2;
        if (n >= 1 && recs[n % 8].ctrl[5]) recs[n % 8].load = m_mem[recs[n % 8].res[6:2]];
        n = m_e - 4;
        if (n >= 1 && recs[n % 8].ctrl[2] && recs[n % 8].dst != 5'd0)
            m_regs[recs[n % 8].dst] = recs[n % 8].ctrl[3] ? recs[n % 8].load : recs[n % 8].res;
        n = m_e - 1;
        if (n >= 1) recs[n % 8] = make_rec(rom[(n - 1) % 32]);
    endtask

    task automatic check_state();
        rec_t r;
        r = (m_e >= 2) ? recs[(m_e - 1) % 8] : make_rec(32'd0);
        check_eq("instr", Instruction, (m_e >= 1) ? rom[(m_e - 1) % 32] : 32'd0);
        check_eq("alu_a", ALU_A, r.a);
        check_eq("alu_b", ALU_B, r.b);
        check_eq("aluout", aluout, r.res);
        check_eq("ctrl", 32'({regdst, alusrc, memread, memwrite, memtoreg, regwrite, aluop}), 32'(r.ctrl));
        check_eq("alucontrol", 32'(alucontrol), 32'(r.actl));
        check_eq("writereg", 32'(writereg), 32'(r.dst));
        check_eq("rt_data", Read_reg_data_2, r.rt);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_state();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq(tag, Instruction | ALU_A | ALU_B | aluout | Read_reg_data_2, 32'd0);
        check_eq({tag, "_ctl"}, 32'({regdst, alusrc, memread, memwrite, memtoreg, regwrite,
                                     aluop, alucontrol, writereg}), 32'd0);
    endtask

    task automatic check_regfile();
        for (int i = 0; i < 32; i++) check_eq($sformatf("reg%0d", i), dut.r_regs[i], m_regs[i]);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'd0;
        rom[0] = 32'h00221820; rom[1] = 32'h00412022; rom[2] = 32'h00C72824;
        rom[3] = 32'h00C94025; rom[4] = 32'h0022502A; rom[5] = 32'hAC070004;
        rom[6] = 32'h8C0B0004;

        reset = 1'b1;
        model_reset();
        #12;
        check_outputs_zero("por_zero");
        @(negedge clk);
        reset = 1'b0;
        #1 check_state();

        // directed pass through the program, including the PC wrap
        for (int e = 1; e <= 40; e++) begin
            step();
            if (e == 1) check_eq("d_instr0", Instruction, 32'h00221820);
            if (e == 2) begin
                check_eq("d_add", aluout, 32'd3);
                check_eq("d_add_ops", {ALU_A[15:0], ALU_B[15:0]}, 32'h0001_0002);
                check_eq("d_add_ctl", 32'({alucontrol, regdst, regwrite, aluop, writereg}), 32'b010_1_1_10_00011);
            end
            if (e == 3) check_eq("d_sub", 32'({alucontrol, aluout[3:0]}), 32'b110_0001);
            if (e == 4) check_eq("d_and", 32'({alucontrol, aluout[3:0]}), 32'b000_0110);
            if (e == 5) check_eq("d_or",  32'({alucontrol, aluout[3:0]}), 32'b001_1111);
            if (e == 6) check_eq("d_slt", 32'({alucontrol, aluout[3:0]}), 32'b111_0001);
            if (e == 7) begin
                check_eq("d_sw", 32'({alusrc, memwrite, regwrite}), 32'b110);
                check_eq("d_sw_b", ALU_B + aluout + Read_reg_data_2, 32'd15);
            end
            if (e == 8) check_eq("d_lw", 32'({memread, memtoreg, writereg}), 32'b1_1_01011);
            if (e == 11) check_eq("d_r11", dut.r_regs[11], 32'd7);
            if (e == 12) begin
                check_eq("d_r3", dut.r_regs[3], 32'd3);
                check_eq("d_r4", dut.r_regs[4], 32'd1);
                check_eq("d_r5", dut.r_regs[5], 32'd6);
                check_eq("d_r8", dut.r_regs[8], 32'd15);
                check_eq("d_r10", dut.r_regs[10], 32'd1);
            end
            if (e == 15) check_eq("d_nop", 32'({regdst, alusrc, memread, memwrite, memtoreg, regwrite, aluop}), 32'd0);
            if (e == 33) check_eq("d_wrap", Instruction, 32'h00221820);
        end
        check_regfile();

        // randomized runs interrupted by asynchronous mid-cycle resets
        for (int k = 0; k < 6; k++) begin
            #($urandom_range(1, 4));
            reset = 1'b1;
            #1 check_outputs_zero("mid_reset");
            model_reset();
            @(negedge clk);
            reset = 1'b0;
            #1 check_state();
            repeat ($urandom_range(2, 45)) step();
            check_regfile();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
